// File: rtl/mcac_pkg.sv
// rtl/mcac_pkg.sv - shared widths and receiver state encoding for the MCAC datapath
package mcac_pkg;
  localparam int PCM_W     = 8;
  localparam int CHAN_W    = 5;
  localparam int MAX_SLOTS = 32;

  typedef enum logic {
    HUNT = 1'b0,
    SYNC = 1'b1
  } rx_state_e;
endpackage

// File: rtl/mcac_sync_fifo.sv
// rtl/mcac_sync_fifo.sv - parameterised synchronous FIFO with same-cycle read/write
module mcac_sync_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_wr, do_rd;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_rd   = rd_en_i && !empty_o;
  assign do_wr   = wr_en_i && (!full_o || do_rd);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
endmodule

// File: rtl/enc_pcm_rx.sv
// rtl/enc_pcm_rx.sv - TDM serial PCM receiver: frame lock, deserialiser and sample FIFO
module enc_pcm_rx
  import mcac_pkg::*;
#(
  parameter int NUM_SLOTS  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scan_in0,
  input  logic              scan_en,
  output logic              scan_out0,
  input  logic              pcm_bit_en,
  input  logic              pcm_din,
  input  logic              pcm_fs,
  output logic              smp_valid,
  input  logic              smp_ready,
  output logic [PCM_W-1:0]  smp_data,
  output logic [CHAN_W-1:0] smp_chan,
  output logic              in_sync,
  output logic              frame_err,
  output logic              ovf
);
  localparam int                FW        = PCM_W + CHAN_W;
  localparam logic [CHAN_W-1:0] LAST_SLOT = CHAN_W'(NUM_SLOTS - 1);

  rx_state_e         state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [CHAN_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [PCM_W-2:0]  shreg_q, shreg_d;
  logic              frame_err_q, frame_err_d;
  logic              ovf_q, ovf_d;

  logic              wr_en, rd_en, fifo_full, fifo_empty, at_frame_start;
  logic [FW-1:0]     wr_word, fifo_rd;
  logic              unused_scan;

  assign unused_scan    = scan_in0 ^ scan_en;
  assign at_frame_start = (bit_cnt_q == 3'd0) && (slot_cnt_q == '0);
  assign wr_word        = {slot_cnt_q, shreg_q, pcm_din};
  assign rd_en          = smp_valid && smp_ready;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    slot_cnt_d  = slot_cnt_q;
    shreg_d     = shreg_q;
    frame_err_d = 1'b0;
    wr_en       = 1'b0;
    if (pcm_bit_en) begin
      case (state_q)
        HUNT: begin
          if (pcm_fs) begin
            state_d    = SYNC;
            shreg_d    = {{(PCM_W-2){1'b0}}, pcm_din};
            bit_cnt_d  = 3'd1;
            slot_cnt_d = '0;
          end
        end
        SYNC: begin
          if (pcm_fs && !at_frame_start) begin
            // Early sync: realign on this bit, partial byte is dropped.
            frame_err_d = 1'b1;
            shreg_d     = {{(PCM_W-2){1'b0}}, pcm_din};
            bit_cnt_d   = 3'd1;
            slot_cnt_d  = '0;
          end else if (!pcm_fs && at_frame_start) begin
            frame_err_d = 1'b1;
            state_d     = HUNT;
          end else begin
            shreg_d   = {shreg_q[PCM_W-3:0], pcm_din};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              wr_en      = 1'b1;
              slot_cnt_d = (slot_cnt_q == LAST_SLOT) ? '0 : slot_cnt_q + CHAN_W'(1);
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
    // A write on a full FIFO survives only if the head leaves on the same edge.
    ovf_d = ovf_q | (wr_en && fifo_full && !rd_en);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= HUNT;
      bit_cnt_q   <= '0;
      slot_cnt_q  <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      slot_cnt_q  <= slot_cnt_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
      ovf_q       <= ovf_d;
    end
  end

  mcac_sync_fifo #(
    .WIDTH(FW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en_i  (wr_en),
    .wr_data_i(wr_word),
    .rd_en_i  (rd_en),
    .rd_data_o(fifo_rd),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  assign smp_valid             = !fifo_empty;
  assign {smp_chan, smp_data}  = smp_valid ? fifo_rd : '0;
  assign in_sync               = (state_q == SYNC);
  assign frame_err             = frame_err_q;
  assign ovf                   = ovf_q;
  assign scan_out0             = 1'b0;
endmodule

// File: tb/tb_enc_pcm_rx.sv
// tb/tb_enc_pcm_rx.sv - self-checking bench for enc_pcm_rx
module tb_enc_pcm_rx;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scan_in0 = 1'b0, scan_en = 1'b0, scan_out0;
  logic       pcm_bit_en = 1'b0, pcm_din = 1'b0, pcm_fs = 1'b0;
  logic       smp_valid, smp_ready = 1'b0;
  logic [7:0] smp_data;
  logic [4:0] smp_chan;
  logic       in_sync, frame_err, ovf;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int fe0;

  logic [12:0] exp_q[$];
  logic [12:0] got_q[$];
  logic        pv = 1'b0;
  logic [12:0] pword = '0;

  enc_pcm_rx #(.NUM_SLOTS(32), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .scan_in0(scan_in0), .scan_en(scan_en),
    .scan_out0(scan_out0), .pcm_bit_en(pcm_bit_en), .pcm_din(pcm_din),
    .pcm_fs(pcm_fs), .smp_valid(smp_valid), .smp_ready(smp_ready),
    .smp_data(smp_data), .smp_chan(smp_chan), .in_sync(in_sync),
    .frame_err(frame_err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset) begin
      pv = 1'b0;
    end else begin
      if (pv) begin
        checks++;
        assert ({smp_valid, smp_chan, smp_data} === {1'b1, pword}) else begin
          errors++;
          $error("FAIL hold_stable observed %0h expected %0h", {smp_valid, smp_chan, smp_data}, {1'b1, pword});
        end
      end
      if (frame_err) fe_cnt++;
      if (smp_valid && smp_ready) got_q.push_back({smp_chan, smp_data});
      pv    = smp_valid && !smp_ready;
      pword = {smp_chan, smp_data};
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic send_bit(input logic d, input logic fs, input logic rp);
    pcm_bit_en = 1'b1;
    pcm_din    = d;
    pcm_fs     = fs;
    if (rp) smp_ready = 1'b1;
    tick();
    pcm_bit_en = 1'b0;
    pcm_fs     = 1'b0;
    if (rp) smp_ready = 1'b0;
    repeat ($urandom_range(1, 2)) tick();
  endtask

  task automatic send_slot(input logic [7:0] b, input int ch, input logic fs,
                           input logic push, input logic rdy_last);
    for (int i = 7; i >= 0; i--) send_bit(b[i], fs && (i == 7), rdy_last && (i == 0));
    if (push) exp_q.push_back({5'(ch), b});
  endtask

  task automatic send_slots(input int first, input int last, input logic push);
    for (int ch = first; ch <= last; ch++)
      send_slot(8'($urandom), ch, ch == 0, push, 1'b0);
  endtask

  task automatic check_drain(input string tag);
    int n = 0;
    while (got_q.size() < exp_q.size() && n < 400) begin
      tick();
      n++;
    end
    repeat (4) tick();
    chk({tag, "_count"}, 16'(got_q.size()), 16'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, "_sample"}, 16'(got_q[i]), 16'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, 16'(smp_valid), 16'd0);
    chk({tag, "_data"}, 16'(smp_data), 16'd0);
    chk({tag, "_chan"}, 16'(smp_chan), 16'd0);
    chk({tag, "_in_sync"}, 16'(in_sync), 16'd0);
    chk({tag, "_frame_err"}, 16'(frame_err), 16'd0);
    chk({tag, "_ovf"}, 16'(ovf), 16'd0);
    chk({tag, "_scan_out"}, 16'(scan_out0), 16'd0);
  endtask

  initial begin
    logic [7:0] b0;
    // Reset state
    repeat (3) tick();
    chk_reset_vals("rst");
    reset = 1'b0;
    tick();
    chk_reset_vals("rst_rel");

    // Lock on first fs, first-sample latency
    b0 = 8'hA5;
    for (int i = 7; i >= 1; i--) send_bit(b0[i], i == 7, 1'b0);
    chk("lock_in_sync", 16'(in_sync), 16'd1);
    chk("lat_before", 16'(smp_valid), 16'd0);
    pcm_bit_en = 1'b1;
    pcm_din    = b0[0];
    tick();
    pcm_bit_en = 1'b0;
    chk("lat_valid", 16'(smp_valid), 16'd1);
    chk("lat_head", 16'({smp_chan, smp_data}), 16'({5'd0, 8'hA5}));
    tick();
    exp_q.push_back({5'd0, 8'hA5});
    smp_ready = 1'b1;
    send_slot(8'h3C, 1, 1'b0, 1'b1, 1'b0);
    send_slots(2, 31, 1'b1);
    check_drain("lock");
    chk("lock_no_ferr", 16'(fe_cnt), 16'd0);
    chk("lock_sync_hold", 16'(in_sync), 16'd1);

    // Simultaneous read and write while full
    smp_ready = 1'b0;
    send_slots(0, 3, 1'b1);
    send_slot(8'($urandom), 4, 1'b0, 1'b1, 1'b1);
    chk("rdwr_ovf_now", 16'(ovf), 16'd0);
    smp_ready = 1'b1;
    check_drain("rdwr");
    chk("rdwr_ovf", 16'(ovf), 16'd0);
    send_slots(5, 31, 1'b1);
    check_drain("rdwr_rest");

    // Backpressure and overflow
    smp_ready = 1'b0;
    send_slots(0, 3, 1'b1);
    chk("bp_no_ovf", 16'(ovf), 16'd0);
    send_slots(4, 4, 1'b0);
    chk("bp_ovf_set", 16'(ovf), 16'd1);
    chk("bp_head", 16'({smp_chan, smp_data}), 16'(exp_q[0]));
    smp_ready = 1'b1;
    check_drain("bp");
    chk("bp_ovf_sticky", 16'(ovf), 16'd1);
    send_slots(5, 31, 1'b1);
    check_drain("bp_rest");

    // Early fs at slot 7, bit 3
    fe0 = fe_cnt;
    send_slots(0, 6, 1'b1);
    for (int i = 0; i < 3; i++) send_bit(1'($urandom), 1'b0, 1'b0);
    send_slot(8'($urandom), 0, 1'b1, 1'b1, 1'b0);
    send_slots(1, 31, 1'b1);
    check_drain("early");
    chk("early_ferr", 16'(fe_cnt - fe0), 16'd1);
    chk("early_sync", 16'(in_sync), 16'd1);

    // Missing fs at the frame boundary, then relock
    fe0 = fe_cnt;
    send_slot(8'($urandom), 0, 1'b0, 1'b0, 1'b0);
    chk("miss_in_sync", 16'(in_sync), 16'd0);
    chk("miss_ferr", 16'(fe_cnt - fe0), 16'd1);
    for (int k = 0; k < 3; k++) send_slot(8'($urandom), k, 1'b0, 1'b0, 1'b0);
    check_drain("miss_quiet");
    send_slots(0, 31, 1'b1);
    check_drain("relock");
    chk("relock_sync", 16'(in_sync), 16'd1);
    chk("relock_ferr", 16'(fe_cnt - fe0), 16'd1);

    // Reset mid-byte with two samples queued
    send_slots(0, 1, 1'b1);
    check_drain("pre_rst");
    smp_ready = 1'b0;
    send_slots(2, 3, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom), 1'b0, 1'b0);
    chk("pre_rst_valid", 16'(smp_valid), 16'd1);
    reset = 1'b1;
    tick();
    chk_reset_vals("mid_rst");
    reset = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) send_slot(8'($urandom), k, 1'b0, 1'b0, 1'b0);
    chk_reset_vals("post_rst");
    check_drain("post_rst_quiet");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/enc_pcm_rx.md
# enc_pcm_rx

TDM serial PCM receiver feeding the `enc` ADPCM encoder in the MCAC datapath. It locks to a frame sync and deserialises 8-bit companded PCM samples from `NUM_SLOTS` timeslots. Each completed sample is buffered together with its channel number in a small FIFO and presented to `enc` over a valid/ready handshake. Framing errors and FIFO overflow are flagged to the control block.

## Interface
Parameters:
- `NUM_SLOTS`, 32, timeslots per frame (2..32)
- `FIFO_DEPTH`, 4, sample FIFO entries (power of two, ≥2)

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `scan_in0`  in  1  DFT scan input; unused before scan insertion
- `scan_en`  in  1  DFT scan enable; unused before scan insertion
- `scan_out0`  out  1  DFT scan output; driven 0 before scan insertion
- `pcm_bit_en`  in  1  one-cycle strobe, one per PCM bit period; `pcm_din` and `pcm_fs` are valid only when it is high
- `pcm_din`  in  1  serial PCM data, MSB first
- `pcm_fs`  in  1  frame sync; high on the MSB bit of slot 0
- `smp_valid`  out  1  FIFO head is valid
- `smp_ready`  in  1  encoder accepts the head
- `smp_data`  out  8  companded PCM sample
- `smp_chan`  out  5  slot number of `smp_data`
- `in_sync`  out  1  receiver is in the SYNC state
- `frame_err`  out  1  one-cycle pulse on a framing error
- `ovf`  out  1  sticky overflow flag; cleared only by `reset`

## Operation
- Only cycles with `pcm_bit_en`=1 are "bit cycles". Counters are `bit_cnt` (0..7) and `slot_cnt` (0..NUM_SLOTS-1).
- **HUNT** (reset state):
  - Data is ignored.
  - A bit cycle with `pcm_fs`=1 loads that bit as bit 0 of slot 0 (`bit_cnt`←1, `slot_cnt`←0) and moves to SYNC.
- **SYNC**:
  - Each bit cycle shifts `pcm_din` into the shift register and increments `bit_cnt`.
  - On `bit_cnt`=7, the byte `{shreg[6:0], pcm_din}` with `slot_cnt` is written to the FIFO on that same edge. `slot_cnt` increments and wraps at NUM_SLOTS-1 → 0.
  - **Expected fs position:** `bit_cnt`=0 and `slot_cnt`=0.
  - **fs=1 at any other position:** pulse `frame_err`, discard the partial byte, and take this bit as bit 0 of slot 0. The state stays SYNC.
  - **fs=0 at the expected position:** pulse `frame_err`, discard the bit, and go to HUNT.
- **FIFO:**
  - A write while full drops the new sample and sets `ovf`.
  - A write and a read on the same edge while full is accepted with no overflow.
  - A read happens when `smp_valid`&&`smp_ready`.
  - `smp_data`/`smp_chan` must stay stable while `smp_valid`=1 and `smp_ready`=0.
- **Reset mid-operation:** FIFO is emptied, counters and shift register are cleared, state → HUNT, and flags are cleared. Any partial byte is lost.

## Timing
- Reset values: `smp_valid`=0, `smp_data`=0, `smp_chan`=0, `in_sync`=0, `frame_err`=0, `ovf`=0, `scan_out0`=0.
- Latency: when the FIFO is empty, `smp_valid` rises the cycle after the edge that captured the 8th bit.
- `in_sync` rises the cycle after the HUNT→SYNC edge. It falls the cycle after the SYNC→HUNT edge.
- `frame_err` is high for exactly the one cycle after the offending bit edge.
- Throughput: one sample per 8 bit cycles. No bubbles are added by the FIFO. A `pcm_bit_en` spacing of ≥2 cycles is guaranteed by the system.
- `smp_ready` may be high without `smp_valid`; that has no effect.

## Structure
- `mcac_pkg`:
  - `PCM_W`=8
  - `CHAN_W`=5
  - `MAX_SLOTS`=32
  - the receiver state enum {HUNT, SYNC}
- Sub-module `mcac_sync_fifo`: a parameterised width/depth synchronous FIFO with `full`/`empty` and same-cycle read/write. It is instantiated with width 13 (data + channel).
- The top level holds the framing FSM, the counters and the shift register.

## Test plan
- **Lock:** `reset` pulse, then fs=1 on the first bit of frame 0xA5,0x3C,… (NUM_SLOTS=32), `smp_ready`=1 → output is (0xA5,ch0), (0x3C,ch1) … ch31. `in_sync`=1, `frame_err` never pulses.
- **Backpressure:** `smp_ready`=0 for 5 samples with FIFO_DEPTH=4 → 4 samples are held stable. The 5th is dropped and `ovf`=1 stays set. After `smp_ready`=1 the output is slots 0..3 in order.
- **Simultaneous read/write when full:** `smp_ready` is pulsed on the same edge as the 5th write → no `ovf`, and all 5 samples are delivered.
- **Early fs:** fs=1 at slot 7, bit 3 → one `frame_err` pulse, no sample for slot 7, and the next sample is tagged ch0.
- **Missing fs:** fs=0 at the frame boundary → `frame_err` pulse, `in_sync`=0, and no samples until the next fs. Relock then restarts at ch0.
- **Reset mid-byte:** `reset` asserted at slot 4, bit 5 with 2 samples queued → all outputs return to reset values, the FIFO is empty and the state is HUNT.
